// File: rtl/i2s_rx_if.sv
// I2S receive bundle: codec-side serial pair in, recovered sample pair and status pulses out.
interface i2s_rx_if #(parameter int BITSIZE = 16);
  logic                      lrclk;
  logic                      sdata;
  logic signed [BITSIZE-1:0] left_chan;
  logic signed [BITSIZE-1:0] right_chan;
  logic                      valid;
  logic                      short_frame;

  modport master (output lrclk, sdata, input left_chan, right_chan, valid, short_frame);
  modport slave  (input lrclk, sdata, output left_chan, right_chan, valid, short_frame);
endinterface

// File: rtl/i2s_rx.sv
// I2S deserializer in the BCLK domain: recovers MSB-first left/right words with one-bit delay,
// framing matched to i2s_tx so an ADC->DAC loopback is bit-exact.
module i2s_rx #(
  parameter int BITSIZE = 16
) (
  input logic     sclk,
  input logic     reset,
  i2s_rx_if.slave bus
);
  // state | meaning
  // SYNC  | after reset, waiting for the first detected lrclk transition
  // SHIFT | capturing data bits of the current slot
  // DONE  | word captured, ignoring slot padding until the next lrclk transition
  typedef enum logic [1:0] {SYNC, SHIFT, DONE} state_t;

  localparam int CW = $clog2(BITSIZE + 1);

  state_t             state_q, state_d;
  logic               lr_q, lr_d;
  logic               primed_q, primed_d;
  logic               ch_q, ch_d;
  logic               left_ok_q, left_ok_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BITSIZE-1:0] shreg_q, shreg_d;
  logic [BITSIZE-1:0] left_q, left_d;
  logic [BITSIZE-1:0] right_q, right_d;
  logic               valid_q, valid_d;
  logic               short_q, short_d;

  logic               frame_edge;
  logic [BITSIZE-1:0] shifted;

  // The priming edge only loads lr_q, so a stale lr_q can never fake a frame edge.
  assign frame_edge = primed_q && (bus.lrclk != lr_q);
  assign shifted    = {shreg_q[BITSIZE-2:0], bus.sdata};

  always_comb begin
    state_d   = state_q;
    lr_d      = bus.lrclk;
    primed_d  = 1'b1;
    ch_d      = ch_q;
    left_ok_d = left_ok_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    short_d   = 1'b0;

    case (state_q)
      SYNC, DONE: begin
        if (frame_edge) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ch_d    = bus.lrclk;
        end
      end
      SHIFT: begin
        if (frame_edge) begin
          // Reaching BITSIZE always leaves SHIFT, so any edge seen here is a short slot.
          short_d   = 1'b1;
          left_ok_d = 1'b0;
          cnt_d     = '0;
          ch_d      = bus.lrclk;
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(BITSIZE - 1)) begin
            state_d = DONE;
            if (!ch_q) begin
              left_d    = shifted;
              left_ok_d = 1'b1;
            end else begin
              right_d   = shifted;
              valid_d   = left_ok_q;
              left_ok_d = 1'b0;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q   <= SYNC;
      lr_q      <= 1'b0;
      primed_q  <= 1'b0;
      ch_q      <= 1'b0;
      left_ok_q <= 1'b0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lr_q      <= lr_d;
      primed_q  <= primed_d;
      ch_q      <= ch_d;
      left_ok_q <= left_ok_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      short_q   <= short_d;
    end
  end

  assign bus.left_chan   = left_q;
  assign bus.right_chan  = right_q;
  assign bus.valid       = valid_q;
  assign bus.short_frame = short_q;
endmodule
